mux_arbiter: RTL

Two-requester round-robin arbiter that shares one 32-bit datapath mux between requester A and requester B and drives its select. Each requester presents data beats with a request/last handshake; the arbiter grants one requester per burst, routes its beats through the mux into a registered output stage, and forwards them downstream under a valid/ready handshake. It sits directly in front of any shared 32-bit sink that is fed from two sources.

---
 rtl/mux_arbiter_pkg.sv | 15 +
 rtl/mux_arbiter_if.sv | 37 +++
 rtl/mux.sv | 16 +
 rtl/mux_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux_arbiter_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    // Source tag carried alongside each output beat
    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester and downstream handshake bundle for mux_arbiter.
// master: the side that sources beats and sinks the output; slave: the arbiter.
interface mux_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             last_a;
    logic             ack_a;

    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             last_b;
    logic             ack_b;

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_owner;
    logic             busy;

    modport master (
        output req_a, data_a, last_a,
        output req_b, data_b, last_b,
        output out_ready,
        input  ack_a, ack_b,
        input  out_data, out_valid, out_owner, busy
    );

    modport slave (
        input  req_a, data_a, last_a,
        input  req_b, data_b, last_b,
        input  out_ready,
        output ack_a, ack_b,
        output out_data, out_valid, out_owner, busy
    );
endinterface

// File: rtl/mux.sv
// Plain 2:1 datapath mux: sel=0 passes a, sel=1 passes b.
module mux #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Pure combinational select
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one datapath mux between requesters A and B.
// One grant per burst; accepted beats land in a single registered output stage
// that drains under a valid/ready handshake.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input logic          clk,
    input logic          rst,
    mux_arbiter_if.slave bus
);

    localparam int unsigned   CW       = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t           state_q;
    logic             prio_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_owner_q;

    logic             sel;
    logic             space;
    logic             ack_a;
    logic             ack_b;
    logic             ack;
    logic             granted;
    logic             cur_req;
    logic             cur_last;
    logic             other_req;
    logic             burst_end;
    logic [WIDTH-1:0] mux_out;

    mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a  (bus.data_a),
        .b  (bus.data_b),
        .sel(sel),
        .y  (mux_out)
    );

    // Grant decode, acks and burst-end detection
    always_comb begin
        granted   = (state_q != IDLE);
        sel       = (state_q == GRANT_B);
        // Output stage can take a beat if empty or draining this cycle
        space     = ~out_valid_q | bus.out_ready;
        ack_a     = (state_q == GRANT_A) & bus.req_a & space;
        ack_b     = (state_q == GRANT_B) & bus.req_b & space;
        ack       = ack_a | ack_b;
        cur_req   = sel ? bus.req_b  : bus.req_a;
        cur_last  = sel ? bus.last_b : bus.last_a;
        other_req = sel ? bus.req_a  : bus.req_b;
        // Withdrawal ends the burst even under backpressure
        burst_end = granted & ((ack & (cur_last | (cnt_q == CNT_LAST))) | ~cur_req);
    end

    // FSM, rotation pointer, beat counter and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= OWNER_A;
        end else begin
            if (ack) begin
                out_data_q  <= mux_out;
                out_owner_q <= sel ? OWNER_B : OWNER_A;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.req_a && (!bus.req_b || !prio_q)) begin
                        state_q <= GRANT_A;
                    end else if (bus.req_b) begin
                        state_q <= GRANT_B;
                    end
                end
                GRANT_A, GRANT_B: begin
                    if (burst_end) begin
                        prio_q <= ~sel;
                        cnt_q  <= '0;
                        if (other_req) begin
                            state_q <= sel ? GRANT_A : GRANT_B;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (ack) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drive the bundle
    assign bus.ack_a     = ack_a;
    assign bus.ack_b     = ack_b;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_owner = out_owner_q;
    assign bus.busy      = granted;

endmodule
